// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing source (x/y, active, syncs, line/frame pulses).
// Define VGA_FRAME_COUNT_EN to add a 16-bit frame_count output.
module vga_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       active,
    output logic       hsync,
    output logic       vsync,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [15:0] frame_count
`endif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    logic       x_wrap;
    logic       frame_wrap;
    logic       hs_on;
    logic       vs_on;
    logic [9:0] x_n;
    logic [9:0] y_n;
    // Out-of-range counts fall into the wrap terms so a corrupted counter recovers in one step.
    always_comb begin
        x_wrap     = x >= X_LAST;
        x_n        = x_wrap ? '0 : x + 10'd1;
        y_n        = (y > Y_LAST || (x_wrap && y == Y_LAST)) ? '0 : x_wrap ? y + 10'd1 : y;
        frame_wrap = x_wrap && y_n == '0;
        hs_on      = int'(x_n) >= H_ACTIVE + H_FP && int'(x_n) < H_ACTIVE + H_FP + H_SYNC;
        vs_on      = int'(y_n) >= V_ACTIVE + V_FP && int'(y_n) < V_ACTIVE + V_FP + V_SYNC;
    end
    // Decoded outputs are registered from the next counter values so they line up with x/y.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x           <= X_LAST;
            y           <= Y_LAST;
            active      <= 1'b0;
            hsync       <= ~HSYNC_POL;
            vsync       <= ~VSYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= ena && x_wrap;
            frame_start <= ena && frame_wrap;
            if (ena) begin
                x      <= x_n;
                y      <= y_n;
                active <= int'(x_n) < H_ACTIVE && int'(y_n) < V_ACTIVE;
                hsync  <= hs_on ? HSYNC_POL : ~HSYNC_POL;
                vsync  <= vs_on ? VSYNC_POL : ~VSYNC_POL;
            end
        end
    end
`ifdef VGA_FRAME_COUNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) frame_count <= '0;
        else if (ena && frame_wrap) frame_count <= frame_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks on a default 640x480 instance and a reduced 16x13 instance
// (positive hsync) that keeps full-frame runs short.
module tb_vga_timing_gen;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena_d = 1'b0;
    logic       ena_s = 1'b0;
    logic [9:0] dx, dy, sx, sy;
    logic       d_act, d_hs, d_vs, d_ls, d_fs;
    logic       s_act, s_hs, s_vs, s_ls, s_fs;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] d_fc, s_fc;
`endif
    int vectors = 0;
    int miscompares = 0;
    int low_cnt, ls_cnt, fs_cnt, hold_err;
    logic [9:0] px, py;
    logic       was_en;

    always #5 clk = ~clk;

    vga_timing_gen u_d (
        .clk(clk), .rst(rst), .ena(ena_d), .x(dx), .y(dy), .active(d_act),
        .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(d_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b0)
    ) u_s (
        .clk(clk), .rst(rst), .ena(ena_s), .x(sx), .y(sy), .active(s_act),
        .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_COUNT_EN
        , .frame_count(s_fc)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        run(3);
        chk("d_rst_x", 32'(dx), 799);
        chk("d_rst_y", 32'(dy), 524);
        chk("d_rst_act", 32'(d_act), 0);
        chk("d_rst_hs", 32'(d_hs), 1);
        chk("d_rst_vs", 32'(d_vs), 1);
        chk("d_rst_ls", 32'(d_ls), 0);
        chk("d_rst_fs", 32'(d_fs), 0);
        chk("s_rst_x", 32'(sx), 15);
        chk("s_rst_y", 32'(sy), 12);
        chk("s_rst_hs", 32'(s_hs), 0);
`ifdef VGA_FRAME_COUNT_EN
        chk("d_rst_fc", 32'(d_fc), 0);
`endif
        rst = 1'b0;
        ena_d = 1'b1;
        ena_s = 1'b1;
        chk("d_pre_x", 32'(dx), 799);
        tick();
        ena_s = 1'b0;
        chk("d_start_x", 32'(dx), 0);
        chk("d_start_y", 32'(dy), 0);
        chk("d_start_act", 32'(d_act), 1);
        chk("d_start_ls", 32'(d_ls), 1);
        chk("d_start_fs", 32'(d_fs), 1);
        chk("s_start_xy", 32'({sx, sy}), 0);
        chk("s_start_fs", 32'(s_fs), 1);
`ifdef VGA_FRAME_COUNT_EN
        chk("d_start_fc", 32'(d_fc), 1);
`endif
        tick();
        chk("d_ls_one_clk", 32'(d_ls), 0);
        chk("d_fs_one_clk", 32'(d_fs), 0);
        run(638);
        chk("d_x639_act", 32'(d_act), 1);
        tick();
        chk("d_x640_x", 32'(dx), 640);
        chk("d_x640_act", 32'(d_act), 0);
        run(15);
        chk("d_x655_hs", 32'(d_hs), 1);
        tick();
        chk("d_x656_hs", 32'(d_hs), 0);
        run(95);
        chk("d_x751_x", 32'(dx), 751);
        chk("d_x751_hs", 32'(d_hs), 0);
        tick();
        chk("d_x752_hs", 32'(d_hs), 1);
        run(47);
        chk("d_x799_y", 32'(dy), 0);
        tick();
        chk("d_line1_x", 32'(dx), 0);
        chk("d_line1_y", 32'(dy), 1);
        chk("d_line1_ls", 32'(d_ls), 1);
        chk("d_line1_fs", 32'(d_fs), 0);
        chk("d_line1_act", 32'(d_act), 1);
        ena_d = 1'b0;
        run(3);
        chk("d_hold_x", 32'(dx), 0);
        chk("d_hold_y", 32'(dy), 1);
        chk("d_hold_ls", 32'(d_ls), 0);
        chk("s_hold_xy", 32'({sx, sy}), 0);

        // small instance: vsync window on lines 8..9
        ena_s = 1'b1;
        run(127);
        chk("s_y7_x15", 32'({sy, sx}), 32'({10'd7, 10'd15}));
        chk("s_y7_vs", 32'(s_vs), 1);
        chk("s_y7_act", 32'(s_act), 0);
        tick();
        chk("s_y8_vs", 32'(s_vs), 0);
        low_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (s_vs == 1'b0) low_cnt++;
            tick();
        end
        chk("s_vs_low_cycles", 32'(low_cnt), 32);
        chk("s_pos_after_vs", 32'({sy, sx}), 32'({10'd10, 10'd8}));
        chk("s_y10_vs", 32'(s_vs), 1);

        // ena toggling every clk over one full frame of enabled cycles
        ls_cnt = 0;
        fs_cnt = 0;
        hold_err = 0;
        for (int i = 0; i < 416; i++) begin
            ena_s = (i % 2 == 0);
            was_en = ena_s;
            px = sx;
            py = sy;
            tick();
            if (!was_en && (sx != px || sy != py)) hold_err++;
            if (s_ls) ls_cnt++;
            if (s_fs) fs_cnt++;
        end
        chk("s_toggle_hold_err", 32'(hold_err), 0);
        chk("s_toggle_ls", 32'(ls_cnt), 13);
        chk("s_toggle_fs", 32'(fs_cnt), 1);
        chk("s_toggle_pos", 32'({sy, sx}), 32'({10'd10, 10'd8}));

        // async reset mid-line while hsync is asserted
        ena_s = 1'b1;
        run(115);
        chk("s_mid_pos", 32'({sy, sx}), 32'({10'd4, 10'd11}));
        chk("s_mid_hs", 32'(s_hs), 1);
        rst = 1'b1;
        #1;
        chk("s_async_x", 32'(sx), 15);
        chk("s_async_y", 32'(sy), 12);
        chk("s_async_hs", 32'(s_hs), 0);
        chk("s_async_vs", 32'(s_vs), 1);
        chk("d_async_x", 32'(dx), 799);
        run(3);
        rst = 1'b0;
        tick();
        chk("s_restart_xy", 32'({sx, sy}), 0);
        chk("s_restart_fs", 32'(s_fs), 1);
        chk("s_restart_ls", 32'(s_ls), 1);
`ifdef VGA_FRAME_COUNT_EN
        chk("s_fc_1", 32'(s_fc), 1);
`endif
        run(207);
        chk("s_frame_end", 32'({sy, sx}), 32'({10'd12, 10'd15}));
        chk("s_frame_end_fs", 32'(s_fs), 0);
`ifdef VGA_FRAME_COUNT_EN
        chk("s_fc_hold", 32'(s_fc), 1);
`endif
        tick();
        chk("s_frame2_fs", 32'(s_fs), 1);
`ifdef VGA_FRAME_COUNT_EN
        chk("s_fc_2", 32'(s_fc), 2);
`endif
        run(208);
        chk("s_frame3_fs", 32'(s_fs), 1);
`ifdef VGA_FRAME_COUNT_EN
        chk("s_fc_3", 32'(s_fc), 3);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
